// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - register map, CTRL bit positions and fade states for rgb_pwm_ctrl
package rgb_pwm_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PRESC  = 3'd1;
  localparam logic [2:0] ADDR_DUTY_R = 3'd2;
  localparam logic [2:0] ADDR_DUTY_G = 3'd3;
  localparam logic [2:0] ADDR_DUTY_B = 3'd4;
  localparam logic [2:0] ADDR_FADE   = 3'd5;
  localparam logic [2:0] ADDR_LEVEL  = 3'd6;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_BREATHE = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_IRQF    = 7;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } fade_state_t;

endpackage

// File: rtl/rgb_pwm_ctrl_pwm_channel.sv
// rtl/rgb_pwm_ctrl_pwm_channel.sv - one colour channel: duty shadow, level scaling, comparator
module pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic       breathe,
  input  logic [7:0] duty,
  input  logic [7:0] level,
  input  logic [7:0] frame_cnt,
  output logic       pwm
);

  logic [7:0]  duty_sh;
  logic [15:0] product;
  logic [7:0]  eff;

  assign product = duty_sh * level;
  assign eff     = breathe ? product[15:8] : duty_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_sh <= 8'd0;
      pwm     <= 1'b0;
    end else begin
      if (load)
        duty_sh <= duty;
      pwm <= en & (frame_cnt < eff);
    end
  end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// rtl/rgb_pwm_ctrl.sv - memory-mapped RGB PWM controller with breathing fade sequencer
module rgb_pwm_ctrl
  import rgb_pwm_pkg::*;
#(
  parameter int PSC_W  = 8,
  parameter int FADE_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       irq
);

  logic              en, breathe, ie, irqf;
  logic [PSC_W-1:0]  presc, psc_cnt;
  logic [7:0]        duty_r, duty_g, duty_b;
  logic [FADE_W-1:0] fade, fade_cnt, fade_cnt_nx, sh_fade;
  logic [7:0]        frame_cnt, level, level_nx, rd_data;
  logic              sh_breathe, tick, boundary, load, irq_set, ctrl_wr;
  fade_state_t       state, state_nx;

  assign ctrl_wr  = cs & we & (addr == ADDR_CTRL);
  assign tick     = en & (psc_cnt == '0);
  assign boundary = tick & (frame_cnt == 8'hFF);
  assign load     = boundary | ~en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en <= 1'b0; breathe <= 1'b0; ie <= 1'b0; irqf <= 1'b0;
      presc <= '0; fade <= '0;
      duty_r <= 8'd0; duty_g <= 8'd0; duty_b <= 8'd0;
    end else begin
      if (cs && we) begin
        case (addr)
          ADDR_CTRL: begin
            en      <= din[CTRL_EN];
            breathe <= din[CTRL_BREATHE];
            ie      <= din[CTRL_IE];
          end
          ADDR_PRESC:  presc  <= PSC_W'(din);
          ADDR_DUTY_R: duty_r <= din;
          ADDR_DUTY_G: duty_g <= din;
          ADDR_DUTY_B: duty_b <= din;
          ADDR_FADE:   fade   <= FADE_W'(din);
          default: ;
        endcase
      end
      // a hardware set in the same cycle as a CPU clear must not be lost
      if (irq_set)
        irqf <= 1'b1;
      else if (ctrl_wr && din[CTRL_IRQF])
        irqf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_cnt <= '0; frame_cnt <= 8'd0; fade_cnt <= '0;
      state <= OFF; level <= 8'd0;
      sh_breathe <= 1'b0; sh_fade <= '0;
    end else if (!en) begin
      psc_cnt <= '0; frame_cnt <= 8'd0; fade_cnt <= '0;
      state <= OFF; level <= 8'd0;
      // pick up BREATHE written together with EN so the first frame already breathes
      sh_breathe <= ctrl_wr ? din[CTRL_BREATHE] : breathe;
      sh_fade    <= fade;
    end else begin
      psc_cnt <= tick ? presc : psc_cnt - 1'b1;
      if (tick)
        frame_cnt <= frame_cnt + 1'b1;
      if (boundary) begin
        sh_breathe <= breathe;
        sh_fade    <= fade;
      end
      state    <= state_nx;
      level    <= level_nx;
      fade_cnt <= fade_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    level_nx    = level;
    fade_cnt_nx = fade_cnt;
    irq_set     = 1'b0;
    if (boundary) begin
      if (!sh_breathe) begin
        state_nx = OFF;
        level_nx = 8'hFF;
      end else begin
        case (state)
          OFF: begin
            state_nx    = RISE;
            level_nx    = 8'd0;
            fade_cnt_nx = '0;
          end
          RISE, FALL: begin
            if (fade_cnt != sh_fade) begin
              fade_cnt_nx = fade_cnt + 1'b1;
            end else begin
              fade_cnt_nx = '0;
              if (state == RISE) begin
                if (level == 8'hFF) state_nx = FALL;
                else                level_nx = level + 1'b1;
              end else begin
                if (level == 8'd0) begin
                  state_nx = RISE;
                  irq_set  = 1'b1;
                end else begin
                  level_nx = level - 1'b1;
                end
              end
            end
          end
          default: state_nx = OFF;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = 8'd0;
    case (addr)
      ADDR_CTRL:   rd_data = {irqf, 4'b0000, ie, breathe, en};
      ADDR_PRESC:  rd_data = 8'(presc);
      ADDR_DUTY_R: rd_data = duty_r;
      ADDR_DUTY_G: rd_data = duty_g;
      ADDR_DUTY_B: rd_data = duty_b;
      ADDR_FADE:   rd_data = 8'(fade);
      ADDR_LEVEL:  rd_data = level;
      default:     rd_data = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= 8'd0;
      irq  <= 1'b0;
    end else begin
      dout <= rd_data;
      irq  <= irqf & ie;
    end
  end

  pwm_channel u_ch_r (.clk(clk), .reset(reset), .en(en), .load(load), .breathe(sh_breathe),
                      .duty(duty_r), .level(level), .frame_cnt(frame_cnt), .pwm(pwm_r));
  pwm_channel u_ch_g (.clk(clk), .reset(reset), .en(en), .load(load), .breathe(sh_breathe),
                      .duty(duty_g), .level(level), .frame_cnt(frame_cnt), .pwm(pwm_g));
  pwm_channel u_ch_b (.clk(clk), .reset(reset), .en(en), .load(load), .breathe(sh_breathe),
                      .duty(duty_b), .level(level), .frame_cnt(frame_cnt), .pwm(pwm_b));

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb/tb_rgb_pwm_ctrl.sv - directed self-checking bench for rgb_pwm_ctrl
module tb_rgb_pwm_ctrl;
  import rgb_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0, we = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic       pwm_r, pwm_g, pwm_b, irq;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;
  int hr = 0, hg = 0, hb = 0;

  always #31 clk = ~clk;

  rgb_pwm_ctrl #(.PSC_W(8), .FADE_W(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .irq(irq)
  );

  // running high-sample counts; a read at a negedge sees samples strictly before it
  always @(negedge clk) begin
    hr <= hr + (pwm_r ? 1 : 0);
    hg <= hg + (pwm_g ? 1 : 0);
    hb <= hb + (pwm_b ? 1 : 0);
  end

  typedef struct {
    logic [2:0] a;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tickn();
    @(negedge clk);
    pos++;
  endtask

  task automatic goto(input int t);
    while (pos < t) tickn();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    tickn();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    addr = a;
    tickn();
    d = dout;
  endtask

  task automatic count_window(input int from, input int to, output int r, output int g, output int b);
    int r0, g0, b0;
    goto(from);
    r0 = hr; g0 = hg; b0 = hb;
    goto(to);
    r = hr - r0; g = hg - g0; b = hb - b0;
  endtask

  initial begin
    #(62 * 200000);
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rv;
    int cr, cg, cb, r0, t1, t2;
    bit prev;

    // reset state
    repeat (3) tickn();
    check("reset_dout", dout, 0);
    check("reset_pwm", {pwm_r, pwm_g, pwm_b}, 0);
    check("reset_irq", irq, 0);
    reset = 1'b0;
    tickn();

    // register write/read-back table
    vt[0] = '{ADDR_CTRL,   8'h06, 8'h06};
    vt[1] = '{ADDR_CTRL,   8'hFE, 8'h06};
    vt[2] = '{ADDR_PRESC,  8'h5A, 8'h5A};
    vt[3] = '{ADDR_DUTY_R, 8'h11, 8'h11};
    vt[4] = '{ADDR_DUTY_G, 8'h22, 8'h22};
    vt[5] = '{ADDR_DUTY_B, 8'h33, 8'h33};
    vt[6] = '{ADDR_FADE,   8'h44, 8'h44};
    vt[7] = '{ADDR_LEVEL,  8'h99, 8'h00};
    vt[8] = '{3'd7,        8'hFF, 8'h00};
    for (int i = 0; i < 9; i++) begin
      wr(vt[i].a, vt[i].wd);
      rd(vt[i].a, rv);
      check($sformatf("regmap_%0d", i), rv, vt[i].exp);
    end
    rd(ADDR_CTRL, rv);
    check("ctrl_kept", rv, 8'h06);
    wr(ADDR_CTRL, 8'h00);

    // static duty
    wr(ADDR_PRESC, 8'd0);
    wr(ADDR_DUTY_R, 8'd64);
    wr(ADDR_DUTY_G, 8'd0);
    wr(ADDR_DUTY_B, 8'd255);
    wr(ADDR_CTRL, 8'h01);
    pos = 0;
    count_window(257, 513, cr, cg, cb);
    check("static_r", cr, 64);
    check("static_g", cg, 0);
    check("static_b", cb, 255);

    // mid-frame duty write lands on the next frame only
    r0 = hr;
    goto(612);
    wr(ADDR_DUTY_R, 8'd200);
    goto(769);
    check("glitch_cur_frame", hr - r0, 64);
    count_window(769, 1025, cr, cg, cb);
    check("glitch_next_frame", cr, 200);

    // disable mid-frame
    goto(1100);
    check("pre_disable_pwm", {pwm_r, pwm_b}, 2'b11);
    wr(ADDR_CTRL, 8'h00);
    tickn();
    check("disable_pwm", {pwm_r, pwm_g, pwm_b}, 0);
    rd(ADDR_LEVEL, rv);
    check("disable_level", rv, 0);
    rd(ADDR_DUTY_R, rv);
    check("disable_duty_r", rv, 200);

    // prescaler
    wr(ADDR_PRESC, 8'd3);
    wr(ADDR_DUTY_R, 8'd128);
    wr(ADDR_CTRL, 8'h01);
    pos = 0;
    count_window(2000, 3024, cr, cg, cb);
    check("presc_high", cr, 512);
    t1 = -1; t2 = -1;
    prev = pwm_r;
    for (int i = 0; i < 2500 && t2 < 0; i++) begin
      tickn();
      if (!prev && pwm_r) begin
        if (t1 < 0) t1 = pos;
        else        t2 = pos;
      end
      prev = pwm_r;
    end
    check("presc_frame_len", (t1 < 0 || t2 < 0) ? -1 : t2 - t1, 1024);

    // async reset mid-operation
    addr = ADDR_DUTY_R;
    tickn();
    check("pre_reset_dout", dout, 128);
    for (int i = 0; i < 2000 && !pwm_r; i++) tickn();
    check("pre_reset_pwm", pwm_r, 1);
    #10 reset = 1'b1;
    #1;
    check("async_reset_pwm", {pwm_r, pwm_g, pwm_b}, 0);
    check("async_reset_dout", dout, 0);
    check("async_reset_irq", irq, 0);
    tickn();
    cs = 1'b1; we = 1'b1; addr = ADDR_DUTY_R; din = 8'h55;
    tickn();
    tickn();
    cs = 1'b0; we = 1'b0;
    reset = 1'b0;
    rd(ADDR_DUTY_R, rv);
    check("write_in_reset", rv, 0);
    rd(ADDR_LEVEL, rv);
    check("reset_level", rv, 0);
    rd(ADDR_CTRL, rv);
    check("reset_ctrl", rv, 0);

    // breathing
    wr(ADDR_PRESC, 8'd0);
    wr(ADDR_FADE, 8'd0);
    wr(ADDR_DUTY_R, 8'd255);
    wr(ADDR_CTRL, 8'h07);
    pos = 0;
    goto(256 * 10 + 5);
    rd(ADDR_LEVEL, rv);
    check("breathe_level_rise", rv, 9);
    count_window(256 * 129 + 1, 256 * 129 + 257, cr, cg, cb);
    check("breathe_scaled_r", cr, 127);
    goto(256 * 257 + 5);
    rd(ADDR_LEVEL, rv);
    check("breathe_level_top", rv, 255);
    goto(256 * 300 + 5);
    rd(ADDR_LEVEL, rv);
    check("breathe_level_fall", rv, 212);
    goto(131320);
    rd(ADDR_CTRL, rv);
    check("pre_irqf", rv, 8'h07);
    goto(131327);
    check("pre_irq", irq, 0);
    wr(ADDR_CTRL, 8'h87);
    check("irq_latency", irq, 0);
    tickn();
    check("irq_set_wins", irq, 1);
    rd(ADDR_CTRL, rv);
    check("irqf_read", rv, 8'h87);
    wr(ADDR_CTRL, 8'h87);
    check("irq_clear_lag", irq, 1);
    tickn();
    check("irq_cleared", irq, 0);
    rd(ADDR_CTRL, rv);
    check("irqf_cleared", rv, 8'h07);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
